hit_bool_pipe: RTL and testbench

Pipelined, parametrised ray-triangle inside test. Takes a plane hit point, the triangle normal and three vertices in signed fixed point, and computes the three edge-cross-dot signs. Returns a hit flag plus per-edge pass mask with a tag. Sits between the p_hit stage and the closest-hit/shading logic, with valid/ready handshakes on both sides.

---
 rtl/hit_bool_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_hit_bool_pipe.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_bool_pipe.sv
// hit_bool_pipe: four-stage ray/triangle inside test on a plane hit point.
// Computes the three edge-cross-dot signs and returns a hit flag.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid / in_ready  input handshake
//   p_hit, normal        {z,y,x} signed fixed point, x in the low bits
//   v0, v1, v2           triangle vertices, same packing
//   in_id                tag carried with the item
//   out_valid/out_ready  output handshake
//   hit                  all three edges pass
//   edge_mask            bit i set when edge i passes
//   out_id               tag of the result
`timescale 1ns/1ps

module hit_bool_pipe #(
  parameter int WIDTH     = 32,
  parameter int Q_BITS    = 10,
  parameter int EDGE_INCL = 0,
  parameter int ID_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*WIDTH-1:0] p_hit,
  input  logic [3*WIDTH-1:0] normal,
  input  logic [3*WIDTH-1:0] v0,
  input  logic [3*WIDTH-1:0] v1,
  input  logic [3*WIDTH-1:0] v2,
  input  logic [ID_W-1:0]    in_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               hit,
  output logic [2:0]         edge_mask,
  output logic [ID_W-1:0]    out_id
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = 2 * WIDTH + 2;

  typedef logic signed [WIDTH-1:0] comp_t;
  typedef logic signed [DW-1:0]    dot_t;

  // a*b - c*d at full precision, floor-shifted,
  // then wrapped back into the component width.
  function automatic comp_t xterm(
    input comp_t a,
    input comp_t b,
    input comp_t c,
    input comp_t d
  );
    logic signed [PW-1:0] m0;
    logic signed [PW-1:0] m1;
    logic signed [PW:0]   df;
    m0 = PW'(a) * PW'(b);
    m1 = PW'(c) * PW'(d);
    df = (PW+1)'(m0) - (PW+1)'(m1);
    df = df >>> Q_BITS;
    return df[WIDTH-1:0];
  endfunction

  function automatic dot_t mulx(
    input comp_t a,
    input comp_t b
  );
    logic signed [PW-1:0] m;
    m = PW'(a) * PW'(b);
    return DW'(m);
  endfunction

  // One enable for the whole pipe: it only
  // stalls when the output slot is blocked.
  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // Input unpacking
  comp_t in_p [3];
  comp_t in_n [3];
  comp_t in_v [3][3];

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      in_p[j]    = p_hit[j*WIDTH +: WIDTH];
      in_n[j]    = normal[j*WIDTH +: WIDTH];
      in_v[0][j] = v0[j*WIDTH +: WIDTH];
      in_v[1][j] = v1[j*WIDTH +: WIDTH];
      in_v[2][j] = v2[j*WIDTH +: WIDTH];
    end
  end

  // S1: edge vectors and point offsets
  comp_t o_nx [3][3];
  comp_t p_nx [3][3];

  always_comb begin
    for (int e = 0; e < 3; e++) begin
      for (int j = 0; j < 3; j++) begin
        o_nx[e][j] = in_v[(e+1)%3][j]
                   - in_v[e][j];
        p_nx[e][j] = in_p[j] - in_v[e][j];
      end
    end
  end

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  comp_t           s1_o [3][3];
  comp_t           s1_p [3][3];
  comp_t           s1_n [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      for (int e = 0; e < 3; e++) begin
        s1_n[e] <= '0;
        for (int j = 0; j < 3; j++) begin
          s1_o[e][j] <= '0;
          s1_p[e][j] <= '0;
        end
      end
    end else if (en) begin
      s1_valid <= in_valid;
      s1_id    <= in_id;
      for (int e = 0; e < 3; e++) begin
        s1_n[e] <= in_n[e];
        for (int j = 0; j < 3; j++) begin
          s1_o[e][j] <= o_nx[e][j];
          s1_p[e][j] <= p_nx[e][j];
        end
      end
    end
  end

  // S2: c_e = o_e x p_e
  comp_t c_nx [3][3];

  always_comb begin
    for (int e = 0; e < 3; e++) begin
      c_nx[e][0] = xterm(s1_o[e][1], s1_p[e][2],
                         s1_o[e][2], s1_p[e][1]);
      c_nx[e][1] = xterm(s1_o[e][2], s1_p[e][0],
                         s1_o[e][0], s1_p[e][2]);
      c_nx[e][2] = xterm(s1_o[e][0], s1_p[e][1],
                         s1_o[e][1], s1_p[e][0]);
    end
  end

  logic            s2_valid;
  logic [ID_W-1:0] s2_id;
  comp_t           s2_c [3][3];
  comp_t           s2_n [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      for (int e = 0; e < 3; e++) begin
        s2_n[e] <= '0;
        for (int j = 0; j < 3; j++) begin
          s2_c[e][j] <= '0;
        end
      end
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      for (int e = 0; e < 3; e++) begin
        s2_n[e] <= s1_n[e];
        for (int j = 0; j < 3; j++) begin
          s2_c[e][j] <= c_nx[e][j];
        end
      end
    end
  end

  // S3: d_e = (c_e . n) >>> Q_BITS,
  // kept wide so the sign is exact.
  dot_t d_nx [3];

  always_comb begin
    for (int e = 0; e < 3; e++) begin
      d_nx[e] = (mulx(s2_c[e][0], s2_n[0])
               + mulx(s2_c[e][1], s2_n[1])
               + mulx(s2_c[e][2], s2_n[2]))
               >>> Q_BITS;
    end
  end

  logic            s3_valid;
  logic [ID_W-1:0] s3_id;
  dot_t            s3_d [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_id    <= '0;
      for (int e = 0; e < 3; e++) begin
        s3_d[e] <= '0;
      end
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_id    <= s2_id;
      for (int e = 0; e < 3; e++) begin
        s3_d[e] <= d_nx[e];
      end
    end
  end

  // S4: sign tests
  logic [2:0] pass;

  always_comb begin
    for (int e = 0; e < 3; e++) begin
      if (EDGE_INCL != 0) begin
        pass[e] = !s3_d[e][DW-1];
      end else begin
        pass[e] = !s3_d[e][DW-1] && (|s3_d[e]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      edge_mask <= '0;
      out_id    <= '0;
    end else if (en) begin
      out_valid <= s3_valid;
      hit       <= &pass;
      edge_mask <= pass;
      out_id    <= s3_id;
    end
  end

endmodule

// File: tb/tb_hit_bool_pipe.sv
// Bench for hit_bool_pipe: three instances (defaults, inclusive edges,
// 24-bit/Q8) checked against an arithmetic model and literal cases.
`timescale 1ns/1ps

module tb_hit_bool_pipe;

  typedef logic signed [127:0] big_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       iv   [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       ordy [3];
  logic       hitv [3];
  logic [2:0] em   [3];
  logic [7:0] idi  [3];
  logic [7:0] ido  [3];

  logic [95:0] vp [2];
  logic [95:0] vn [2];
  logic [95:0] va [2];
  logic [95:0] vb [2];
  logic [95:0] vc [2];
  logic [71:0] wp, wn, wa, wb, wc;

  hit_bool_pipe u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .p_hit(vp[0]), .normal(vn[0]),
    .v0(va[0]), .v1(vb[0]), .v2(vc[0]),
    .in_id(idi[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .hit(hitv[0]), .edge_mask(em[0]),
    .out_id(ido[0])
  );

  hit_bool_pipe #(.EDGE_INCL(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .p_hit(vp[1]), .normal(vn[1]),
    .v0(va[1]), .v1(vb[1]), .v2(vc[1]),
    .in_id(idi[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .hit(hitv[1]), .edge_mask(em[1]),
    .out_id(ido[1])
  );

  hit_bool_pipe #(.WIDTH(24), .Q_BITS(8)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .p_hit(wp), .normal(wn),
    .v0(wa), .v1(wb), .v2(wc),
    .in_id(idi[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .hit(hitv[2]), .edge_mask(em[2]),
    .out_id(ido[2])
  );

  int sp [3][3];
  int sn [3][3];
  int sv [3][3][3];
  int tv [3][3];

  logic [11:0] sb [3][$];
  logic [11:0] prev  [3];
  bit          stall [3];
  int          npop  [3];

  int checks   = 0;
  int failures = 0;

  function automatic void chk(
    input string       nm,
    input int          k,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t",
               nm, k, act, exp, $time);
    end
  endfunction

  function automatic big_t wrapw(input big_t v, input int w);
    big_t t;
    t = v <<< (128 - w);
    return t >>> (128 - w);
  endfunction

  // Edge e runs from vertex e to vertex e+1; the point is
  // inside that edge when (edge x (p - v_e)) . n is positive.
  function automatic logic [3:0] model(input int k);
    int         w;
    int         q;
    bit         inc;
    int         b;
    big_t       o  [3];
    big_t       pp [3];
    big_t       c  [3];
    big_t       n  [3];
    big_t       d;
    logic [2:0] m;
    w   = (k == 2) ? 24 : 32;
    q   = (k == 2) ? 8 : 10;
    inc = (k == 1);
    for (int j = 0; j < 3; j++) begin
      n[j] = wrapw(big_t'(sn[k][j]), w);
    end
    for (int e = 0; e < 3; e++) begin
      b = (e + 1) % 3;
      for (int j = 0; j < 3; j++) begin
        o[j]  = wrapw(big_t'(sv[k][b][j])
                    - big_t'(sv[k][e][j]), w);
        pp[j] = wrapw(big_t'(sp[k][j])
                    - big_t'(sv[k][e][j]), w);
      end
      c[0] = wrapw((o[1]*pp[2] - o[2]*pp[1]) >>> q, w);
      c[1] = wrapw((o[2]*pp[0] - o[0]*pp[2]) >>> q, w);
      c[2] = wrapw((o[0]*pp[1] - o[1]*pp[0]) >>> q, w);
      d = (c[0]*n[0] + c[1]*n[1] + c[2]*n[2]) >>> q;
      m[e] = inc ? (d >= 0) : (d > 0);
    end
    return {&m, m};
  endfunction

  // Single compare process for all three instances
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        chk("rst_ov", k, 32'(ov[k]), 32'd0);
        chk("rst_hit", k, 32'(hitv[k]), 32'd0);
        chk("rst_mask", k, 32'(em[k]), 32'd0);
        chk("rst_id", k, 32'(ido[k]), 32'd0);
        chk("rst_ir", k, 32'(ir[k]), 32'd0);
        sb[k].delete();
        stall[k] = 1'b0;
      end else begin
        chk("in_ready", k, 32'(ir[k]),
            32'(!ov[k] || ordy[k]));
        if (stall[k]) begin
          chk("hold", k,
              32'({hitv[k], em[k], ido[k]}),
              32'(prev[k]));
        end
        if (ov[k]) begin
          if (sb[k].size() == 0) begin
            chk("spurious", k, 32'(ov[k]), 32'd0);
          end else begin
            chk("result", k,
                32'({hitv[k], em[k], ido[k]}),
                32'(sb[k][0]));
            if (ordy[k]) begin
              void'(sb[k].pop_front());
              npop[k]++;
            end
          end
        end
        if (iv[k] && ir[k]) begin
          sb[k].push_back({model(k), idi[k]});
        end
        stall[k] = ov[k] && !ordy[k];
        prev[k]  = {hitv[k], em[k], ido[k]};
      end
    end
  end

  function automatic logic [95:0] pk32(
    input int x, input int y, input int z
  );
    return {z, y, x};
  endfunction

  function automatic logic [71:0] pk24(
    input int x, input int y, input int z
  );
    logic [23:0] a, b, c;
    a = x[23:0];
    b = y[23:0];
    c = z[23:0];
    return {c, b, a};
  endfunction

  task automatic set_tri(input int u);
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 3; j++) begin
        tv[v][j] = 0;
      end
    end
    tv[1][0] = 4 * u;
    tv[2][1] = 4 * u;
  endtask

  // Called just after a rising edge; returns just after the
  // edge that accepted the item.
  task automatic send(
    input int k,
    input int px, input int py, input int pz,
    input int nx, input int ny, input int nz,
    input int id
  );
    int t;
    sp[k][0] = px; sp[k][1] = py; sp[k][2] = pz;
    sn[k][0] = nx; sn[k][1] = ny; sn[k][2] = nz;
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 3; j++) begin
        sv[k][v][j] = tv[v][j];
      end
    end
    if (k < 2) begin
      vp[k] = pk32(px, py, pz);
      vn[k] = pk32(nx, ny, nz);
      va[k] = pk32(tv[0][0], tv[0][1], tv[0][2]);
      vb[k] = pk32(tv[1][0], tv[1][1], tv[1][2]);
      vc[k] = pk32(tv[2][0], tv[2][1], tv[2][2]);
    end else begin
      wp = pk24(px, py, pz);
      wn = pk24(nx, ny, nz);
      wa = pk24(tv[0][0], tv[0][1], tv[0][2]);
      wb = pk24(tv[1][0], tv[1][1], tv[1][2]);
      wc = pk24(tv[2][0], tv[2][1], tv[2][2]);
    end
    idi[k] = id[7:0];
    iv[k]  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ir[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ir[k]) chk("send_timeout", k, 32'(ir[k]), 32'd1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while ((sb[k].size() != 0 || ov[k]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", k, 32'(sb[k].size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Out_valid must rise on the 4th rising edge counting
  // the accept edge as the first.
  task automatic run_one(
    input int k,
    input int px, input int py, input int pz,
    input int nx, input int ny, input int nz,
    input int id,
    input logic [2:0] xm,
    input logic xh
  );
    int n;
    send(k, px, py, pz, nx, ny, nz, id);
    n = 1;
    while (!ov[k] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", k, 32'(n), 32'd4);
    chk("mask", k, 32'(em[k]), 32'(xm));
    chk("hit", k, 32'(hitv[k]), 32'(xh));
    chk("id", k, 32'(ido[k]), 32'(id));
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      idi[k]  = '0;
      npop[k] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      vp[k] = '0; vn[k] = '0;
      va[k] = '0; vb[k] = '0; vc[k] = '0;
    end
    wp = '0; wn = '0; wa = '0; wb = '0; wc = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Literal cases, Q10 triangle (0,0)-(4,0)-(0,4)
    set_tri(1024);
    run_one(0, 1024, 1024, 0, 0, 0, 1024, 1, 3'b111, 1'b1);
    run_one(0, 5120, 5120, 0, 0, 0, 1024, 2, 3'b101, 1'b0);
    run_one(0, 2048, 0, 0, 0, 0, 1024, 3, 3'b110, 1'b0);
    run_one(1, 2048, 0, 0, 0, 0, 1024, 3, 3'b111, 1'b1);
    run_one(1, 1024, 1024, 0, 0, 0, 1024, 4, 3'b111, 1'b1);
    // Zero normal
    run_one(0, 1024, 1024, 0, 0, 0, 0, 5, 3'b000, 1'b0);
    run_one(1, 1024, 1024, 0, 0, 0, 0, 6, 3'b111, 1'b1);
    // Zero-area triangle
    set_tri(0);
    run_one(0, 1024, 1024, 0, 0, 0, 1024, 7, 3'b000, 1'b0);
    run_one(1, 1024, 1024, 0, 0, 0, 1024, 8, 3'b111, 1'b1);
    set_tri(1024);

    // Backpressure: five back-to-back, 3-cycle stall
    base = npop[0];
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          if (i % 2 == 1)
            send(0, 1024, 1024, 0, 0, 0, 1024, i);
          else
            send(0, 5120, 5120, 0, 0, 0, 1024, i);
        end
      end
      begin
        int t;
        t = 0;
        while (!ov[0] && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        ordy[0] = 1'b0;
        #1;
        chk("stall_ir", 0, 32'(ir[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    drain(0);
    chk("bp_count", 0, 32'(npop[0] - base), 32'd5);

    // Reset with three items in flight
    send(0, 1024, 1024, 0, 0, 0, 1024, 6);
    send(0, 5120, 5120, 0, 0, 0, 1024, 7);
    send(0, 1024, 1024, 0, 0, 0, 1024, 8);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 0, 32'(ov[0]), 32'd0);
    chk("mid_rst_id", 0, 32'(ido[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_one(0, 1024, 1024, 0, 0, 0, 1024, 9, 3'b111, 1'b1);

    // 24-bit / Q8 instance: literal then 16-item burst
    set_tri(256);
    run_one(2, 256, 256, 0, 0, 0, 256, 10, 3'b111, 1'b1);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(2, i * 80, (15 - i) * 50, 0, 0, 0, 256, 32 + i);
        end
      end
      begin
        int t;
        int run;
        t = 0;
        run = 0;
        while (!ov[2] && t < 100) begin
          @(negedge clk);
          t++;
        end
        while (ov[2] && run < 40) begin
          run++;
          @(negedge clk);
        end
        chk("burst_len", 2, 32'(run), 32'd16);
      end
    join
    for (int k = 0; k < 3; k++) begin
      drain(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
